ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: the send-side counterpart of the keyboard receive path. It sends one command byte to the keyboard, such as 0xED for set-LEDs, 0xF4 for enable, or 0xFF for reset. It sits beside the keyboard decoder on the shared PS2_CLK/PS2_DATA pins and drives them open-drain through top-level tri-states (`pin = oe ? 1'b0 : 1'bz`). `busy` tells the decoder to ignore line activity while a transmission is in progress.

---
 rtl/ps2_host_tx_if.sv | 12 +
 rtl/ps2_host_tx.sv | 139 +++++++++++++
 tb/tb_ps2_host_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic       busy;

  modport master (output tx_valid, tx_data, input tx_ready, tx_done, tx_err, busy);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx_done, tx_err, busy);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/8 data/parity/stop
// on device-generated clocks, checks the ack bit and reports done or error.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE
  } state_t;

  state_t         state, state_nxt;
  logic           clk_s1, clk_s2, clk_s3, data_s1, data_s2;
  logic           fall, accept, inhibit_end, timeout;
  logic [7:0]     byte_q;
  logic           par_q;
  logic [2:0]     bit_cnt;
  logic [CW-1:0]  cnt;
  logic           ready_q, busy_q, done_q, err_q;
  logic           clk_oe_nxt, data_oe_nxt, done_nxt, err_nxt;

  assign fall        = clk_s2 & ~clk_s3;
  assign accept      = bus.tx_valid && ready_q;
  assign inhibit_end = (cnt == CW'(INHIBIT_CYCLES - 1));
  assign timeout     = (state inside {START, DATA, PARITY, STOP, ACK, WAIT_IDLE}) &&
                       (cnt == CW'(TIMEOUT_CYCLES - 1));

  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = err_q;

  // Pin synchronisers idle high so a reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {clk_s1, clk_s2, clk_s3, data_s1, data_s2} <= '1;
    end else begin
      clk_s1  <= ps2_clk_i;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data_i;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      ps2_clk_oe  <= clk_oe_nxt;
      ps2_data_oe <= data_oe_nxt;
      ready_q     <= (state_nxt == IDLE);
      busy_q      <= (state_nxt != IDLE);
      done_q      <= done_nxt;
      err_q       <= err_nxt;
    end
  end

  // One counter times the inhibit phase, then restarts at START as the frame timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_q  <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        byte_q <= bus.tx_data;
        par_q  <= ~^bus.tx_data;
      end
      if (state == IDLE)
        bit_cnt <= '0;
      else if (state == DATA && fall)
        bit_cnt <= bit_cnt + 3'd1;
      if (state == IDLE || state_nxt == IDLE || (state == INHIBIT && inhibit_end))
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (accept) state_nxt = INHIBIT;
        INHIBIT:   if (inhibit_end) state_nxt = START;
        START:     state_nxt = DATA;
        DATA:      if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:    if (fall) state_nxt = STOP;
        STOP:      if (fall) state_nxt = ACK;
        ACK:       if (fall) state_nxt = data_s2 ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (clk_s2 && data_s2) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; data_oe is the inverse of the bit on the wire.
  always_comb begin
    clk_oe_nxt  = (state_nxt == INHIBIT) || (state_nxt == START);
    data_oe_nxt = ps2_data_oe;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    if (state_nxt == START) begin
      data_oe_nxt = 1'b1;
    end else if (state_nxt == IDLE) begin
      data_oe_nxt = 1'b0;
    end else if (fall) begin
      case (state)
        DATA:    data_oe_nxt = ~byte_q[bit_cnt];
        PARITY:  data_oe_nxt = ~par_q;
        STOP:    data_oe_nxt = 1'b0;
        default: data_oe_nxt = ps2_data_oe;
      endcase
    end
    err_nxt  = timeout || (state == ACK && fall && data_s2);
    done_nxt = !timeout && (state == WAIT_IDLE) && clk_s2 && data_s2;
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain bus and a PS/2 device model.
module tb_ps2_host_tx;
  localparam int INH = 200;
  localparam int TMO = 3000;
  localparam int HP  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();
  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic clk_line, data_line;
  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ps2_clk_i(clk_line), .ps2_data_i(data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  int total = 0;
  int bad   = 0;

  // Event monitors: accepts on the active edge, everything else away from it.
  int cyc = 0, accepts = 0, last_accept_cyc = -1;
  always @(posedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      accepts         <= accepts + 1;
      last_accept_cyc <= cyc;
    end
    cyc <= cyc + 1;
  end

  int n_done = 0, n_err = 0, clk_oe_cycles = 0;
  int last_rise_cyc = -1, last_err_cyc = -1, last_done_cyc = -1;
  logic prev_doe = 1'b0, err_clk_oe = 1'b1, err_data_oe = 1'b1, err_ready = 1'b0;
  always @(negedge clk) begin
    if (ps2_clk_oe) clk_oe_cycles <= clk_oe_cycles + 1;
    if (ps2_data_oe && !prev_doe) last_rise_cyc <= cyc;
    prev_doe <= ps2_data_oe;
    if (bus.tx_done) begin
      n_done        <= n_done + 1;
      last_done_cyc <= cyc;
    end
    if (bus.tx_err) begin
      n_err        <= n_err + 1;
      last_err_cyc <= cyc;
      err_clk_oe   <= ps2_clk_oe;
      err_data_oe  <= ps2_data_oe;
      err_ready    <= bus.tx_ready;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_parity(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return (ones % 2) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    for (int i = 0; i < 200 && !bus.tx_ready; i++) tick();
    checkOutput("ready_before_send", bus.tx_ready, 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    checkOutput("accept_busy", bus.busy, 1);
    checkOutput("accept_clk_oe", ps2_clk_oe, 1);
    checkOutput("accept_ready", bus.tx_ready, 0);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      if (clk_line && !data_line) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("start_seen", ok, 1);
  endtask

  task automatic dev_pulse(output logic s);
    repeat (HP) tick();
    dev_clk_low = 1'b1;
    repeat (HP) tick();
    dev_clk_low = 1'b0;
    s = data_line;
  endtask

  task automatic device_frame(input bit ack, output logic [7:0] got, output logic gpar, output logic gstop);
    bit ok;
    logic s;
    got = 'x; gpar = 1'bx; gstop = 1'bx;
    wait_start(ok);
    if (!ok) return;
    for (int i = 0; i < 8; i++) begin
      dev_pulse(s);
      got[i] = s;
    end
    dev_pulse(gpar);
    dev_pulse(gstop);
    dev_data_low = ack;
    dev_pulse(s);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < TMO + INH + 200 && bus.busy; i++) tick();
    checkOutput("idle_reached", bus.busy, 0);
    tick();
  endtask

  task automatic run_byte(input logic [7:0] b, input string tag);
    int d0, e0, c0;
    logic [7:0] got;
    logic gp, gs;
    d0 = n_done; e0 = n_err; c0 = clk_oe_cycles;
    applyStimulus(b);
    device_frame(1'b1, got, gp, gs);
    wait_not_busy();
    checkOutput({tag, "_byte"}, got, b);
    checkOutput({tag, "_parity"}, gp, model_parity(b));
    checkOutput({tag, "_stop"}, gs, 1);
    checkOutput({tag, "_done_once"}, n_done - d0, 1);
    checkOutput({tag, "_no_err"}, n_err - e0, 0);
    checkOutput({tag, "_clk_oe_len"}, clk_oe_cycles - c0, INH + 1);
  endtask

  initial begin
    int d0, e0, a0;
    logic [7:0] got;
    logic gp, gs, s;
    bit ok;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    #2 rst = 1'b0;
    #1;
    checkOutput("rst_clk_oe", ps2_clk_oe, 0);
    checkOutput("rst_data_oe", ps2_data_oe, 0);
    checkOutput("rst_ready", bus.tx_ready, 1);
    checkOutput("rst_done", bus.tx_done, 0);
    checkOutput("rst_err", bus.tx_err, 0);
    checkOutput("rst_busy", bus.busy, 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();

    run_byte(8'hED, "ed");
    run_byte(8'h00, "x00");
    run_byte(8'h07, "x07");
    run_byte(8'hFF, "xff");
    for (int i = 0; i < 4; i++) run_byte(8'($urandom_range(0, 255)), "rand");

    // Device leaves data high on the 11th clock.
    d0 = n_done; e0 = n_err;
    applyStimulus(8'h5A);
    device_frame(1'b0, got, gp, gs);
    wait_not_busy();
    checkOutput("noack_err", n_err - e0, 1);
    checkOutput("noack_done", n_done - d0, 0);
    checkOutput("noack_clk_oe", err_clk_oe, 0);
    checkOutput("noack_data_oe", err_data_oe, 0);
    checkOutput("noack_ready", err_ready, 1);

    // Device never clocks.
    d0 = n_done; e0 = n_err;
    applyStimulus(8'h3C);
    wait_not_busy();
    checkOutput("tmo_err", n_err - e0, 1);
    checkOutput("tmo_done", n_done - d0, 0);
    checkOutput("tmo_latency", last_err_cyc - last_rise_cyc, TMO);
    checkOutput("tmo_clk_oe", err_clk_oe, 0);
    checkOutput("tmo_data_oe", err_data_oe, 0);

    // Reset while bit 4 is on the wire.
    d0 = n_done; e0 = n_err;
    applyStimulus(8'hA5);
    wait_start(ok);
    for (int i = 0; i < 4; i++) dev_pulse(s);
    repeat (HP) tick();
    dev_clk_low = 1'b1;
    repeat (5) tick();
    checkOutput("mid_bit4_driven", ps2_data_oe, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_clk_oe", ps2_clk_oe, 0);
    checkOutput("mid_rst_data_oe", ps2_data_oe, 0);
    dev_clk_low = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("mid_rst_no_done", n_done - d0, 0);
    checkOutput("mid_rst_no_err", n_err - e0, 0);
    run_byte(8'hF4, "f4");

    // tx_valid held across a whole transaction.
    d0 = n_done; a0 = accepts;
    bus.tx_data  = 8'h96;
    bus.tx_valid = 1'b1;
    tick();
    device_frame(1'b1, got, gp, gs);
    for (int i = 0; i < 100 && !bus.tx_done; i++) tick();
    checkOutput("hold_done_seen", bus.tx_done, 1);
    checkOutput("hold_single_accept", accepts - a0, 1);
    bus.tx_data = 8'h69;
    tick();
    bus.tx_valid = 1'b0;
    checkOutput("hold_first_byte", got, 8'h96);
    checkOutput("hold_second_accept", accepts - a0, 2);
    checkOutput("hold_accept_after_done", last_accept_cyc, last_done_cyc);
    device_frame(1'b1, got, gp, gs);
    wait_not_busy();
    checkOutput("hold_second_byte", got, 8'h69);
    checkOutput("hold_second_parity", gp, model_parity(8'h69));
    checkOutput("hold_done_count", n_done - d0, 2);
    checkOutput("hold_accept_count", accepts - a0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
